load_use_scoreboard: RTL and testbench

- Producer-side companion to the forwarding unit. Keeps a shadow pipeline of in-flight register writes through EX, DCACHE and MEM.
- For the instruction in ID, decides whether its sources can be satisfied by forwarding or whether ID must stall because a producing load has not yet returned data.
- Sits beside the ID stage. Drives the ID stall request into the pipeline control block.

---
 rtl/load_use_scoreboard_pkg.sv | 27 ++
 rtl/load_use_scoreboard_if.sv | 37 +++
 rtl/load_use_scoreboard_sb_slot.sv | 29 ++
 rtl/load_use_scoreboard.sv | 78 +++++++
 tb/tb_load_use_scoreboard.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/load_use_scoreboard_pkg.sv
// Load-use scoreboard shared types and constants.
// Shadow-pipeline entry format and stall-vector bit positions.
package load_use_scoreboard_pkg;

  typedef logic [5:0] stall_bus_t;
  typedef logic [4:0] reg_addr_t;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_DC  = 4;
  localparam int STALL_MEM = 5;

  localparam int NUM_SLOTS       = 3;
  localparam int SLOT_EX         = 0;
  localparam int SLOT_DC         = 1;
  localparam int SLOT_MEM        = 2;
  localparam int LOAD_READY_SLOT = SLOT_MEM;

  typedef struct packed {
    logic      valid;
    reg_addr_t waddr;
    logic      is_load;
  } sb_entry_t;

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-side bundle of the load-use scoreboard.
// master = pipeline/ID stage, slave = scoreboard.
interface load_use_scoreboard_if;
  import load_use_scoreboard_pkg::*;

  logic       flush;
  stall_bus_t stall;
  logic       id_valid;
  logic       id_we;
  reg_addr_t  id_waddr;
  logic       id_is_load;
  reg_addr_t  rs_raddr;
  logic       rs_used;
  reg_addr_t  rt_raddr;
  logic       rt_used;
  logic       stallreq_load;
  logic       rs_pending;
  logic       rt_pending;
  logic [1:0] loads_inflight;

  modport master (
    output flush, stall,
    output id_valid, id_we, id_waddr, id_is_load,
    output rs_raddr, rs_used, rt_raddr, rt_used,
    input  stallreq_load, rs_pending, rt_pending,
    input  loads_inflight
  );

  modport slave (
    input  flush, stall,
    input  id_valid, id_we, id_waddr, id_is_load,
    input  rs_raddr, rs_used, rt_raddr, rt_used,
    output stallreq_load, rs_pending, rt_pending,
    output loads_inflight
  );

endinterface

// File: rtl/load_use_scoreboard_sb_slot.sv
// One shadow-pipeline slot: load, hold, bubble or flush.
// own_stall holds the slot; up_stall alone inserts a bubble.
module sb_slot
  import load_use_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      up_stall,
  input  logic      own_stall,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!own_stall) begin
      if (up_stall) begin
        q.valid <= 1'b0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: shadows in-flight writes in EX/DCACHE/MEM
// and requests an ID stall when a consumer needs unreturned load data.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
(
  input logic clk,
  input logic rst,
  load_use_scoreboard_if.slave sb
);

  sb_entry_t slot_d [NUM_SLOTS];
  sb_entry_t slot_q [NUM_SLOTS];

  logic unused_stall;
  assign unused_stall = ^{sb.stall[STALL_IF], sb.stall[STALL_PC]};

  always_comb begin
    slot_d[0].valid   = sb.id_valid & sb.id_we
                      & (sb.id_waddr != '0);
    slot_d[0].waddr   = sb.id_waddr;
    slot_d[0].is_load = sb.id_is_load;
    for (int s = 1; s < NUM_SLOTS; s++) begin
      slot_d[s] = slot_q[s-1];
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sb_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (sb.flush),
      .up_stall  (sb.stall[STALL_ID+g]),
      .own_stall (sb.stall[STALL_ID+g+1]),
      .d         (slot_d[g]),
      .q         (slot_q[g])
    );
  end

  logic [NUM_SLOTS-1:0] rs_hit;
  logic [NUM_SLOTS-1:0] rt_hit;
  logic                 rs_block;
  logic                 rt_block;
  logic [1:0]           loads;

  // Walk oldest to youngest so the youngest match decides readiness.
  always_comb begin
    rs_hit   = '0;
    rt_hit   = '0;
    rs_block = 1'b0;
    rt_block = 1'b0;
    loads    = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      rs_hit[s] = slot_q[s].valid & sb.rs_used
                & (slot_q[s].waddr == sb.rs_raddr)
                & (sb.rs_raddr != '0);
      rt_hit[s] = slot_q[s].valid & sb.rt_used
                & (slot_q[s].waddr == sb.rt_raddr)
                & (sb.rt_raddr != '0);
      if (rs_hit[s]) begin
        rs_block = slot_q[s].is_load
                 & (s < LOAD_READY_SLOT);
      end
      if (rt_hit[s]) begin
        rt_block = slot_q[s].is_load
                 & (s < LOAD_READY_SLOT);
      end
      loads = loads
            + 2'(slot_q[s].valid & slot_q[s].is_load);
    end
  end

  assign sb.stallreq_load  = sb.id_valid
                           & (rs_block | rt_block);
  assign sb.rs_pending     = |rs_hit;
  assign sb.rt_pending     = |rt_hit;
  assign sb.loads_inflight = loads;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed, table-driven bench for the load-use scoreboard.
// Each row drives ID/stall inputs, checks outputs, then clocks.
module tb_load_use_scoreboard;
  import load_use_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  load_use_scoreboard_if bus ();

  load_use_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [5:0] stall;
    logic       idv;
    logic       we;
    logic [4:0] wa;
    logic       ld;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic       e_st;
    logic       e_rsp;
    logic       e_rtp;
    logic [1:0] e_li;
  } vec_t;

  localparam int NS  = 0;
  localparam int S7  = 7;
  localparam int S15 = 15;

  function automatic vec_t mk(
    int r, int f, int st, int iv, int we, int wa, int ld,
    int rs, int ru, int rt, int tu,
    int es, int erp, int etp, int eli);
    vec_t v;
    v.rst   = 1'(r);
    v.flush = 1'(f);
    v.stall = 6'(st);
    v.idv   = 1'(iv);
    v.we    = 1'(we);
    v.wa    = 5'(wa);
    v.ld    = 1'(ld);
    v.rs    = 5'(rs);
    v.rsu   = 1'(ru);
    v.rt    = 5'(rt);
    v.rtu   = 1'(tu);
    v.e_st  = 1'(es);
    v.e_rsp = 1'(erp);
    v.e_rtp = 1'(etp);
    v.e_li  = 2'(eli);
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    bus.flush      = v.flush;
    bus.stall      = v.stall;
    bus.id_valid   = v.idv;
    bus.id_we      = v.we;
    bus.id_waddr   = v.wa;
    bus.id_is_load = v.ld;
    bus.rs_raddr   = v.rs;
    bus.rs_used    = v.rsu;
    bus.rt_raddr   = v.rt;
    bus.rt_used    = v.rtu;
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, " stallreq"}, {1'b0, bus.stallreq_load}, {1'b0, v.e_st});
    chk({tag, " rs_pend"}, {1'b0, bus.rs_pending}, {1'b0, v.e_rsp});
    chk({tag, " rt_pend"}, {1'b0, bus.rt_pending}, {1'b0, v.e_rtp});
    chk({tag, " loads"}, bus.loads_inflight, v.e_li);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl [$];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // load-use: LW $5 then ADDU $6,$5,$7
    tbl.push_back(mk(0,0,NS,  1,1,5,1,  1,1,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,S7,  1,1,6,0,  5,1,7,1,  1,1,0,1));
    tbl.push_back(mk(0,0,S7,  1,1,6,0,  5,1,7,1,  1,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,1,6,0,  5,1,7,1,  0,1,0,1));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  0,0,0,0,  0,0,0,0));
    // ADDU $5, LW $8, consumers of $5 / $8
    tbl.push_back(mk(0,0,NS,  1,1,5,0,  1,1,2,1,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  1,1,8,1,  5,1,0,0,  0,1,0,0));
    tbl.push_back(mk(0,0,NS,  1,1,9,0,  5,1,10,1, 0,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  5,1,8,1,  1,1,1,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  5,1,8,1,  0,0,1,1));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  0,0,0,0,  0,0,0,0));
    // youngest match is ready: LW $3 in DC, ADDIU $3 in EX
    tbl.push_back(mk(0,0,NS,  1,1,3,1,  1,1,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  1,1,3,0,  3,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  3,1,0,1,  0,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  3,1,0,0,  0,1,0,1));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  0,0,0,0,  0,0,0,0));
    // flush kills LW $4
    tbl.push_back(mk(0,0,NS,  1,1,4,1,  1,1,0,0,  0,0,0,0));
    tbl.push_back(mk(0,1,NS,  1,0,0,0,  4,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  4,1,0,0,  0,0,0,0));
    // EX held three cycles with LW $9, then release
    tbl.push_back(mk(0,0,NS,  1,1,9,1,  1,1,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,S15, 1,1,10,0, 9,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,S15, 1,1,10,0, 9,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,S15, 1,1,10,0, 9,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,S7,  1,1,10,0, 9,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,S7,  1,1,10,0, 9,1,0,0,  1,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,1,10,0, 9,1,0,0,  0,1,0,1));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  10,1,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  10,1,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  10,1,0,0, 0,1,0,0));
    // $0 as load destination, then read $0
    tbl.push_back(mk(0,0,NS,  1,1,0,1,  0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  1,0,0,0,  0,1,0,1,  0,0,0,0));
    // three loads in flight, then rst
    tbl.push_back(mk(0,0,NS,  1,1,1,1,  0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,NS,  1,1,2,1,  0,0,0,0,  0,0,0,1));
    tbl.push_back(mk(0,0,NS,  1,1,3,1,  0,0,0,0,  0,0,0,2));
    tbl.push_back(mk(1,0,NS,  0,0,0,0,  1,1,2,1,  0,1,1,3));
    tbl.push_back(mk(0,0,NS,  0,0,0,0,  1,1,2,1,  0,0,0,0));

    drive(mk(1,0,NS, 0,0,0,0, 0,0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(mk(1,0,NS, 0,0,0,0, 0,0,0,0, 0,0,0,0), "reset");

    foreach (tbl[i]) begin
      step(tbl[i], $sformatf("r%0d", i));
    end

    // flush wins over a held EX slot
    step(mk(0,0,NS,  1,1,7,1, 0,0,0,0, 0,0,0,0), "fh0");
    step(mk(0,1,S15, 1,0,0,0, 7,1,0,0, 1,1,0,1), "fh1");
    step(mk(0,0,S15, 1,0,0,0, 7,1,0,0, 0,0,0,0), "fh2");
    // rst wins over a held EX slot
    step(mk(0,0,NS,  1,1,7,1, 0,0,0,0, 0,0,0,0), "rh0");
    step(mk(1,0,S15, 0,0,0,0, 7,1,0,0, 0,1,0,1), "rh1");
    step(mk(0,0,S15, 1,0,0,0, 7,1,0,0, 0,0,0,0), "rh2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
